// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: parametrised VGA raster controller for a frame-buffer display.
// Generates sync/blank timing, issues one framebuffer read per active pixel with
// an incrementing linear address, and realigns syncs/blank with returned data
// across RD_LAT clocks of memory latency. Optional feature macro: TEST_PATTERN_EN
// (adds pattern_sel input and an 8-bar colour test pattern).
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIX_W    = 1,
    parameter int COL_W    = 10,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic [PIX_W-1:0]  Data,
`ifdef TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              hsync,
    output logic              vsync,
    output logic              vga_blank,
    output logic              vga_sync,
    output logic [COL_W-1:0]  red,
    output logic [COL_W-1:0]  green,
    output logic [COL_W-1:0]  blue,
    output logic              Read,
    output logic [ADDR_W-1:0] Addr,
    output logic              frame_start
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          act_raw;
    logic          hs_raw;
    logic          vs_raw;
    logic          frame_zero;

    // Index 0 of each chain is the raw combinational value; index n is n clocks later.
    logic [RD_LAT:0]   act_pipe, hs_pipe, vs_pipe;
    logic [RD_LAT+1:0] act_chain, hs_chain, vs_chain;
    logic [COL_W-1:0]  grey;

    // Replicate the pixel MSB-first across the colour channel width.
    function automatic logic [COL_W-1:0] expand(input logic [PIX_W-1:0] d);
        logic [COL_W-1:0] r;
        r = '0;
        for (int i = 0; i < COL_W; i++) begin
            r[COL_W-1-i] = d[PIX_W-1-(i % PIX_W)];
        end
        return r;
    endfunction

    // Horizontal/vertical position counters; vc advances on hc wrap.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    // Raw timing decoded straight from the counters.
    always_comb begin
        act_raw    = (hc >= H_ACT_BEG) && (hc < H_ACT_END) &&
                     (vc >= V_ACT_BEG) && (vc < V_ACT_END);
        hs_raw     = (hc < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vs_raw     = (vc < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        frame_zero = (hc == '0) && (vc == '0);
        grey       = expand(Data);
    end

    assign act_chain = {act_pipe, act_raw};
    assign hs_chain  = {hs_pipe, hs_raw};
    assign vs_chain  = {vs_pipe, vs_raw};

    assign Read      = act_chain[1];
    assign vga_blank = act_chain[RD_LAT+1];
    assign hsync     = hs_chain[RD_LAT+1];
    assign vsync     = vs_chain[RD_LAT+1];
    assign vga_sync  = 1'b0;

    // Alignment pipeline: the first stage doubles as the Read strobe.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            act_pipe <= '0;
            hs_pipe  <= {(RD_LAT+1){~SYNC_POL}};
            vs_pipe  <= {(RD_LAT+1){~SYNC_POL}};
        end else begin
            act_pipe <= act_chain[RD_LAT:0];
            hs_pipe  <= hs_chain[RD_LAT:0];
            vs_pipe  <= vs_chain[RD_LAT:0];
        end
    end

    // Frame-start pulse and incrementing read address, saturating at the last pixel.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            frame_start <= 1'b0;
            Addr        <= '0;
        end else begin
            frame_start <= frame_zero;
            if (frame_zero) begin
                Addr <= '0;
            end else if (Read && (Addr != ADDR_LAST)) begin
                Addr <= Addr + 1'b1;
            end
        end
    end

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [HW-1:0]           hoff;
    logic [2:0]              bar_raw;
    logic [RD_LAT:0][2:0]    bar_pipe;
    logic [RD_LAT+1:0][2:0]  bar_chain;

    // Bar index from horizontal offset into the active region, by threshold compare.
    always_comb begin
        hoff    = hc - H_ACT_BEG;
        bar_raw = '0;
        for (int b = 1; b < 8; b++) begin
            if (hoff >= HW'(b * BAR_W)) begin
                bar_raw = 3'(b);
            end
        end
    end

    assign bar_chain = {bar_pipe, bar_raw};

    // Carry the bar index alongside the active flag so bars line up with vga_blank.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            bar_pipe <= '0;
        end else begin
            bar_pipe <= bar_chain[RD_LAT:0];
        end
    end
`endif

    // Colour output register, zero outside active video.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (!act_chain[RD_LAT]) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
`ifdef TEST_PATTERN_EN
        end else if (pattern_sel) begin
            red   <= {COL_W{~bar_chain[RD_LAT][1]}};
            green <= {COL_W{~bar_chain[RD_LAT][2]}};
            blue  <= {COL_W{~bar_chain[RD_LAT][0]}};
`endif
        end else begin
            red   <= grey;
            green <= grey;
            blue  <= grey;
        end
    end

endmodule
